// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// There is no handshake: every field is sampled every cycle, and the outputs are meaningful every cycle.
interface hazard_ctrl_if #(
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
);
    logic [RADDR_W-1:0] RA1D;
    logic [RADDR_W-1:0] RA2D;
    logic [RADDR_W-1:0] WA3D;
    logic               RegWriteD;
    logic               MemtoRegD;
    logic               PCSrcD;
    logic               RegWriteEout;
    logic               PCSrcEout;
    logic               BranchTakenE;
    logic               cnt_clr;
    logic [1:0]         ForwardAE;
    logic [1:0]         ForwardBE;
    logic               StallF;
    logic               StallD;
    logic               FlushD;
    logic               FlushE;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
        output RegWriteEout, PCSrcEout, BranchTakenE, cnt_clr,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
        input  RegWriteEout, PCSrcEout, BranchTakenE, cnt_clr,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage ARM pipeline: forwarding selects, stall/flush controls,
// a private shadow pipeline of destination tags, and saturating debug event counters.
module hazard_ctrl #(
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16,
    parameter int PC_REG  = 15
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam logic [RADDR_W-1:0] PC_IDX  = RADDR_W'(PC_REG);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [RADDR_W-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
    logic               reg_write_e, mem_to_reg_e, pc_src_e;
    logic               reg_write_m, pc_src_m;
    logic               reg_write_w, pc_src_w;
    logic               ldr_stall, pc_wr_pending, flush_e;
    logic [CNT_W-1:0]   stall_q, flush_q;

    // M beats W; the PC register is never forwarded since its reads come from the fetch path.
    function automatic logic [1:0] fwd_sel(
        input logic [RADDR_W-1:0] src,
        input logic               rw_m,
        input logic [RADDR_W-1:0] wa_m,
        input logic               rw_w,
        input logic [RADDR_W-1:0] wa_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != PC_IDX) begin
            if (rw_m && (wa_m == src))
                sel = 2'b10;
            else if (rw_w && (wa_w == src))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ldr_stall     = mem_to_reg_e & reg_write_e
                      & ((wa3_e == hz.RA1D) | (wa3_e == hz.RA2D))
                      & ~hz.BranchTakenE;
        pc_wr_pending = hz.PCSrcD | pc_src_e | pc_src_m;
        flush_e       = ldr_stall | hz.BranchTakenE;
    end

    // Outputs are forced low while reset is asserted, even though D/E inputs may still toggle.
    assign hz.ForwardAE = rst ? fwd_sel(ra1_e, reg_write_m, wa3_m, reg_write_w, wa3_w) : 2'b00;
    assign hz.ForwardBE = rst ? fwd_sel(ra2_e, reg_write_m, wa3_m, reg_write_w, wa3_w) : 2'b00;
    assign hz.StallF    = rst & (ldr_stall | pc_wr_pending);
    assign hz.StallD    = rst & ldr_stall;
    assign hz.FlushD    = rst & (pc_wr_pending | pc_src_w | hz.BranchTakenE);
    assign hz.FlushE    = rst & flush_e;
    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra1_e        <= '0;
            ra2_e        <= '0;
            wa3_e        <= '0;
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            pc_src_e     <= 1'b0;
        end else if (flush_e) begin
            ra1_e        <= '0;
            ra2_e        <= '0;
            wa3_e        <= '0;
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            pc_src_e     <= 1'b0;
        end else begin
            ra1_e        <= hz.RA1D;
            ra2_e        <= hz.RA2D;
            wa3_e        <= hz.WA3D;
            reg_write_e  <= hz.RegWriteD;
            mem_to_reg_e <= hz.MemtoRegD;
            pc_src_e     <= hz.PCSrcD;
        end
    end

    // M captures the condition-qualified execute results, not the raw decode flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa3_m       <= '0;
            reg_write_m <= 1'b0;
            pc_src_m    <= 1'b0;
            wa3_w       <= '0;
            reg_write_w <= 1'b0;
            pc_src_w    <= 1'b0;
        end else begin
            wa3_m       <= wa3_e;
            reg_write_m <= hz.RegWriteEout;
            pc_src_m    <= hz.PCSrcEout;
            wa3_w       <= wa3_m;
            reg_write_w <= reg_write_m;
            pc_src_w    <= pc_src_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (hz.cnt_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (ldr_stall && (stall_q != CNT_MAX))
                stall_q <= stall_q + 1'b1;
            if (hz.BranchTakenE && (flush_q != CNT_MAX))
                flush_q <= flush_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written corner sequences,
// and random traffic checked against a stage-list model of the pipeline.
module tb_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    hazard_ctrl_if #(.RADDR_W(4), .CNT_W(16)) hz ();

    hazard_ctrl #(.RADDR_W(4), .CNT_W(16), .PC_REG(15)) dut (
        .clk (clk),
        .rst (rst_n),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ra1, ra2, wa3;
        logic       rw, mtr, pcs;
    } stage_t;

    typedef struct {
        int ra1, ra2, wa3, rwd, mtrd, pcsd, rweo, pceo, bte;
        int fa, fb, sf, sd, fd, fe;
    } vec_t;

    // Model pipeline: index 0 = E, 1 = M, 2 = W (only wa3/rw/pcs matter past E).
    stage_t pipe [3];
    int     m_stall, m_flush;
    vec_t   tbl [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int m_fwd(input logic [3:0] src);
        int sel;
        sel = 0;
        if (src != 4'd15) begin
            for (int s = 2; s >= 1; s--)
                if (pipe[s].rw && pipe[s].wa3 == src) sel = (s == 1) ? 2 : 1;
        end
        return sel;
    endfunction

    function automatic bit m_ldr();
        return pipe[0].mtr && pipe[0].rw && !hz.BranchTakenE &&
               (pipe[0].wa3 == hz.RA1D || pipe[0].wa3 == hz.RA2D);
    endfunction

    function automatic bit m_pend();
        return hz.PCSrcD || pipe[0].pcs || pipe[1].pcs;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) pipe[s] = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_advance();
        bit     ldr;
        stage_t nxt_m;
        stage_t nxt_e;
        ldr = m_ldr();
        if (hz.cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (ldr && m_stall < 65535) m_stall++;
            if (hz.BranchTakenE && m_flush < 65535) m_flush++;
        end
        nxt_m     = '0;
        nxt_m.wa3 = pipe[0].wa3;
        nxt_m.rw  = hz.RegWriteEout;
        nxt_m.pcs = hz.PCSrcEout;
        nxt_e     = '0;
        if (!(ldr || hz.BranchTakenE)) begin
            nxt_e.ra1 = hz.RA1D;
            nxt_e.ra2 = hz.RA2D;
            nxt_e.wa3 = hz.WA3D;
            nxt_e.rw  = hz.RegWriteD;
            nxt_e.mtr = hz.MemtoRegD;
            nxt_e.pcs = hz.PCSrcD;
        end
        pipe[2] = pipe[1];
        pipe[1] = nxt_m;
        pipe[0] = nxt_e;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive(input vec_t v);
        hz.RA1D         = 4'(v.ra1);
        hz.RA2D         = 4'(v.ra2);
        hz.WA3D         = 4'(v.wa3);
        hz.RegWriteD    = v.rwd[0];
        hz.MemtoRegD    = v.mtrd[0];
        hz.PCSrcD       = v.pcsd[0];
        hz.RegWriteEout = v.rweo[0];
        hz.PCSrcEout    = v.pceo[0];
        hz.BranchTakenE = v.bte[0];
    endtask

    function automatic vec_t row(input int ra1, ra2, wa3, rwd, mtrd, pcsd, rweo, pceo, bte,
                                 input int fa, fb, sf, sd, fd, fe);
        vec_t v;
        v.ra1 = ra1; v.ra2 = ra2; v.wa3 = wa3; v.rwd = rwd; v.mtrd = mtrd; v.pcsd = pcsd;
        v.rweo = rweo; v.pceo = pceo; v.bte = bte;
        v.fa = fa; v.fb = fb; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
        return v;
    endfunction

    task automatic cmp_model(input string tag);
        bit ldr, pend;
        ldr  = m_ldr();
        pend = m_pend();
        chk({tag, " ForwardAE"}, int'(hz.ForwardAE), m_fwd(pipe[0].ra1));
        chk({tag, " ForwardBE"}, int'(hz.ForwardBE), m_fwd(pipe[0].ra2));
        chk({tag, " StallF"}, int'(hz.StallF), int'(ldr | pend));
        chk({tag, " StallD"}, int'(hz.StallD), int'(ldr));
        chk({tag, " FlushD"}, int'(hz.FlushD), int'(pend | pipe[2].pcs | hz.BranchTakenE));
        chk({tag, " FlushE"}, int'(hz.FlushE), int'(ldr | hz.BranchTakenE));
        chk({tag, " stall_cnt"}, int'(hz.stall_cnt), m_stall);
        chk({tag, " flush_cnt"}, int'(hz.flush_cnt), m_flush);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ForwardAE"}, int'(hz.ForwardAE), 0);
        chk({tag, " ForwardBE"}, int'(hz.ForwardBE), 0);
        chk({tag, " StallF"}, int'(hz.StallF), 0);
        chk({tag, " StallD"}, int'(hz.StallD), 0);
        chk({tag, " FlushD"}, int'(hz.FlushD), 0);
        chk({tag, " FlushE"}, int'(hz.FlushE), 0);
        chk({tag, " stall_cnt"}, int'(hz.stall_cnt), 0);
        chk({tag, " flush_cnt"}, int'(hz.flush_cnt), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(row(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        hz.cnt_clr = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    function automatic int rnd_reg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 15 : r;
    endfunction

    initial begin
        int exp_stall, exp_flush;
        vec_t v;

        // Reset with noisy inputs: outputs must still be held low.
        rst_n      = 1'b0;
        hz.cnt_clr = 1'b0;
        drive(row(4,4,4,1,1,1,1,1,1, 0,0,0,0,0,0));
        model_reset();
        #3;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        do_reset();

        // Columns: ra1 ra2 wa3 rwD mtrD pcsD rwEo pcEo bte | fa fb sf sd fd fe
        tbl.push_back(row( 7, 8, 1,1,0,0, 0,0,0, 0,0,0,0,0,0)); // ADD R1
        tbl.push_back(row( 1, 3, 2,1,0,0, 1,0,0, 0,0,0,0,0,0)); // SUB R2,R1,R3
        tbl.push_back(row( 1,10, 9,1,0,0, 1,0,0, 2,0,0,0,0,0)); // M forward
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 1,0,0,0,0,0)); // W forward
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 7, 8, 1,1,0,0, 0,0,0, 0,0,0,0,0,0)); // ADD R1, cond fails
        tbl.push_back(row( 1, 3, 2,1,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 1,10, 9,1,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row(11, 0, 4,1,1,0, 0,0,0, 0,0,0,0,0,0)); // LDR R4
        tbl.push_back(row( 4, 6, 5,1,0,0, 1,0,0, 0,0,1,1,0,1)); // load-use stall
        tbl.push_back(row( 4, 6, 5,1,0,0, 0,0,0, 0,0,0,0,0,0)); // repeated D, bubble in E
        tbl.push_back(row( 0, 0, 0,0,0,0, 1,0,0, 1,0,0,0,0,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row(11, 0, 4,1,1,0, 0,0,0, 0,0,0,0,0,0)); // LDR R4
        tbl.push_back(row( 4, 6, 5,1,0,0, 1,0,1, 0,0,0,0,1,1)); // branch squashes stall
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 2, 0,15,1,0,1, 0,0,0, 0,0,1,0,1,0)); // write R15
        tbl.push_back(row(15, 1, 6,1,0,0, 1,1,0, 0,0,1,0,1,0)); // reader of R15
        tbl.push_back(row( 0, 0, 0,0,0,0, 1,0,0, 0,0,1,0,1,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,1,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 7, 0, 0,1,0,0, 0,0,0, 0,0,0,0,0,0)); // MOV R0
        tbl.push_back(row( 0, 0, 3,1,0,0, 1,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 2,2,0,0,0,0)); // R0 forwarded from M
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 1,1,0,0,0,0)); // R0 forwarded from W
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 7,12, 1,1,0,0, 0,0,0, 0,0,0,0,0,0)); // ADD R1
        tbl.push_back(row( 8,12, 1,1,0,0, 1,0,0, 0,0,0,0,0,0)); // SUB R1
        tbl.push_back(row( 1,10, 9,1,0,0, 1,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 2,0,0,0,0,0)); // M beats W
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(row( 0, 0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));

        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v);
            @(negedge clk);
            chk($sformatf("vec%0d ForwardAE", i), int'(hz.ForwardAE), v.fa);
            chk($sformatf("vec%0d ForwardBE", i), int'(hz.ForwardBE), v.fb);
            chk($sformatf("vec%0d StallF", i), int'(hz.StallF), v.sf);
            chk($sformatf("vec%0d StallD", i), int'(hz.StallD), v.sd);
            chk($sformatf("vec%0d FlushD", i), int'(hz.FlushD), v.fd);
            chk($sformatf("vec%0d FlushE", i), int'(hz.FlushE), v.fe);
            exp_stall += v.sd;
            exp_flush += v.bte;
            tick();
        end
        chk("table stall_cnt", int'(hz.stall_cnt), exp_stall);
        chk("table flush_cnt", int'(hz.flush_cnt), exp_flush);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            hz.RA1D         = 4'(rnd_reg());
            hz.RA2D         = 4'(rnd_reg());
            hz.WA3D         = 4'(rnd_reg());
            hz.RegWriteD    = ($urandom_range(0, 3) != 0);
            hz.MemtoRegD    = ($urandom_range(0, 2) == 0);
            hz.PCSrcD       = ($urandom_range(0, 9) == 0);
            hz.RegWriteEout = ($urandom_range(0, 1) == 1);
            hz.PCSrcEout    = ($urandom_range(0, 9) == 0);
            hz.BranchTakenE = ($urandom_range(0, 6) == 0);
            hz.cnt_clr      = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            cmp_model($sformatf("rnd%0d", c));
            tick();
        end
        hz.cnt_clr = 1'b0;

        // Counter saturation and clear priority.
        do_reset();
        drive(row(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0));
        for (int c = 0; c < 70000; c++) tick();
        @(negedge clk);
        chk("sat flush_cnt", int'(hz.flush_cnt), 65535);
        chk("sat stall_cnt", int'(hz.stall_cnt), 0);
        tick();
        hz.cnt_clr = 1'b1;
        @(negedge clk);
        chk("pre-clr flush_cnt", int'(hz.flush_cnt), 65535);
        tick();
        hz.cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr flush_cnt", int'(hz.flush_cnt), 0);
        tick();
        @(negedge clk);
        chk("post-clr flush_cnt", int'(hz.flush_cnt), 1);
        tick();

        // Reset asserted in the middle of a load-use stall.
        do_reset();
        drive(row(11,0,4,1,1,0, 0,0,0, 0,0,0,0,0,0));
        tick();
        drive(row(4,6,5,1,0,0, 1,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        chk("mid-stall StallD", int'(hz.StallD), 1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("async reset");
        #1;
        rst_n = 1'b1;
        #1;
        chk("post-reset StallD", int'(hz.StallD), 0);
        chk("post-reset FlushE", int'(hz.FlushE), 0);
        tick();
        @(negedge clk);
        cmp_model("post-reset cycle");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
